vga_timing_gen: RTL

Produces VGA raster timing: the row/col pixel coordinates, the active-video qualifier, and the hsync/vsync pulses. It is the upstream driver for the colour generator. Its row, col and output_valid outputs feed the colour generator's matching inputs. Its hsync/vsync go straight to the VGA connector, alongside the colour generator's rgb.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, col/row raster counters,
// and registered active-video / sync / strobe outputs decoded from the
// coordinates being presented on the same edge (zero skew between outputs).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [10:0] col,
  output logic [10:0] row,
  output logic        output_valid,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_en,
  output logic        frame_start
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Divider and raster state
  logic [DIV_W-1:0] div_cnt;
  logic             started;

  // Next-state values
  logic [DIV_W-1:0] div_cnt_nxt;
  logic             started_nxt;
  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;
  logic             output_valid_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             pix_en_nxt;
  logic             frame_start_nxt;

  logic tick_c;

  // Pixel tick: last system clock of the current pixel period
  assign tick_c = (div_cnt == DIV_LAST);

  // Next-state: divider, raster advance, and decode of the new coordinates
  always_comb begin
    div_cnt_nxt      = div_cnt;
    started_nxt      = started;
    col_nxt          = col;
    row_nxt          = row;
    output_valid_nxt = output_valid;
    hsync_nxt        = hsync;
    vsync_nxt        = vsync;
    pix_en_nxt       = 1'b0;
    frame_start_nxt  = 1'b0;

    if (!enable) begin
      // Disabled: return everything to the idle/reset picture
      div_cnt_nxt      = '0;
      started_nxt      = 1'b0;
      col_nxt          = '0;
      row_nxt          = '0;
      output_valid_nxt = 1'b0;
      hsync_nxt        = ~SYNC_POL;
      vsync_nxt        = ~SYNC_POL;
    end else begin
      div_cnt_nxt = tick_c ? '0 : DIV_W'(div_cnt + 1'b1);

      if (tick_c) begin
        pix_en_nxt = 1'b1;

        // First tick presents (0,0) without advancing the counters
        if (!started) begin
          started_nxt = 1'b1;
          col_nxt     = '0;
          row_nxt     = '0;
        end else if (col == H_LAST) begin
          col_nxt = '0;
          row_nxt = (row == V_LAST) ? '0 : CNT_W'(row + 1'b1);
        end else begin
          col_nxt = CNT_W'(col + 1'b1);
        end

        output_valid_nxt = (col_nxt < H_VIS) && (row_nxt < V_VIS);
        hsync_nxt        = ((col_nxt >= HS_START) && (col_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_nxt        = ((row_nxt >= VS_START) && (row_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        frame_start_nxt  = (col_nxt == '0) && (row_nxt == '0);
      end
    end
  end

  // State and output registers with asynchronous reset to the idle picture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      started      <= 1'b0;
      col          <= '0;
      row          <= '0;
      output_valid <= 1'b0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      pix_en       <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      div_cnt      <= div_cnt_nxt;
      started      <= started_nxt;
      col          <= col_nxt;
      row          <= row_nxt;
      output_valid <= output_valid_nxt;
      hsync        <= hsync_nxt;
      vsync        <= vsync_nxt;
      pix_en       <= pix_en_nxt;
      frame_start  <= frame_start_nxt;
    end
  end

endmodule
